// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide unit: one radix-2 datapath shared by shift-add
// multiply and restoring divide, answering the core's mdu_valid/mdu_ready handshake.
module mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mdu_valid,
    input  logic [2:0]      mdu_op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            mdu_ready,
    output logic [XLEN-1:0] mdu_result,
    output logic            mdu_busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_op;
    logic                r_signA;
    logic                r_neg;
    logic [XLEN-1:0]     r_b;
    logic [2*XLEN-1:0]   r_acc;
    logic [CW-1:0]       r_cnt;
    logic [XLEN-1:0]     r_result;

    logic                w_signedA;
    logic                w_signedB;
    logic                w_signA;
    logic                w_signB;
    logic [XLEN-1:0]     w_absA;
    logic [XLEN-1:0]     w_absB;
    logic                w_divZero;
    logic                w_overflow;
    logic                w_special;
    logic [XLEN-1:0]     w_specialRes;

    logic [XLEN-1:0]     w_accHi;
    logic [XLEN-1:0]     w_accLo;
    logic [XLEN:0]       w_mulSum;
    logic [2*XLEN-1:0]   w_mulStep;
    logic [XLEN:0]       w_remShift;
    logic [XLEN:0]       w_remDiff;
    logic                w_remGe;
    logic [2*XLEN-1:0]   w_divStep;
    logic [2*XLEN-1:0]   w_product;
    logic [XLEN-1:0]     w_quot;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fixRes;

    // Operand decode at the accept edge: signs and magnitudes feed the unsigned datapath.
    assign w_signedA  = (mdu_op == 3'b001) || (mdu_op == 3'b010) ||
                        (mdu_op == 3'b100) || (mdu_op == 3'b110);
    assign w_signedB  = (mdu_op == 3'b001) || (mdu_op == 3'b100) || (mdu_op == 3'b110);
    assign w_signA    = w_signedA & rs1[XLEN-1];
    assign w_signB    = w_signedB & rs2[XLEN-1];
    assign w_absA     = w_signA ? -rs1 : rs1;
    assign w_absB     = w_signB ? -rs2 : rs2;
    assign w_divZero  = mdu_op[2] && (rs2 == '0);
    assign w_overflow = mdu_op[2] && !mdu_op[0] && (rs1 == MIN_INT) && (rs2 == '1);
    assign w_special  = w_divZero || w_overflow;

    always_comb begin
        w_specialRes = '0;
        if (w_divZero) begin
            w_specialRes = mdu_op[1] ? rs1 : '1;
        end else if (w_overflow) begin
            w_specialRes = mdu_op[1] ? '0 : MIN_INT;
        end
    end

    // Multiply keeps {partial product, multiplier}; divide keeps {remainder, dividend/quotient}.
    assign w_accHi    = r_acc[2*XLEN-1:XLEN];
    assign w_accLo    = r_acc[XLEN-1:0];
    assign w_mulSum   = {1'b0, w_accHi} + (w_accLo[0] ? {1'b0, r_b} : '0);
    assign w_mulStep  = {w_mulSum, w_accLo[XLEN-1:1]};
    assign w_remShift = {w_accHi, w_accLo[XLEN-1]};
    assign w_remGe    = w_remShift >= {1'b0, r_b};
    assign w_remDiff  = w_remShift - {1'b0, r_b};
    assign w_divStep  = {(w_remGe ? w_remDiff[XLEN-1:0] : w_remShift[XLEN-1:0]),
                         w_accLo[XLEN-2:0], w_remGe};

    assign w_product  = r_neg ? -r_acc : r_acc;
    assign w_quot     = r_neg ? -w_accLo : w_accLo;
    assign w_rem      = r_signA ? -w_accHi : w_accHi;

    always_comb begin
        w_fixRes = '0;
        case (r_op)
            3'b000:                 w_fixRes = w_product[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fixRes = w_product[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fixRes = w_quot;
            default:                w_fixRes = w_rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (mdu_valid) w_next = w_special ? DONE : CALC;
            CALC: if (r_cnt == CW'(1)) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: if (!mdu_valid) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath registers; mdu_result only changes on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_signA  <= 1'b0;
            r_neg    <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mdu_valid) begin
                        r_op    <= mdu_op;
                        r_signA <= w_signA;
                        r_neg   <= w_signA ^ w_signB;
                        r_b     <= w_absB;
                        r_acc   <= {{XLEN{1'b0}}, w_absA};
                        r_cnt   <= CW'(XLEN);
                        if (w_special) r_result <= w_specialRes;
                    end
                end
                CALC: begin
                    r_acc <= r_op[2] ? w_divStep : w_mulStep;
                    r_cnt <= r_cnt - 1'b1;
                end
                FIX:  r_result <= w_fixRes;
                default: ;
            endcase
        end
    end

    assign mdu_ready  = (r_state == DONE);
    assign mdu_busy   = (r_state == CALC) || (r_state == FIX);
    assign mdu_result = r_result;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed RV32M cases, special cases, handshake,
// asynchronous reset and randomized operations against an arithmetic reference model.
module tb_mdu_seq;

    localparam int XLEN = 32;
    localparam int NORMAL_LAT = XLEN + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            mdu_valid;
    logic [2:0]      mdu_op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            mdu_ready;
    logic [XLEN-1:0] mdu_result;
    logic            mdu_busy;

    int checks = 0;
    int errors = 0;

    mdu_seq #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .mdu_valid(mdu_valid), .mdu_op(mdu_op),
        .rs1(rs1), .rs2(rs2), .mdu_ready(mdu_ready), .mdu_result(mdu_result),
        .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics from 64-bit products and native signed/unsigned division.
    function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int sa, sb;
        ea = (op == 3'b001 || op == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        sa = a;
        sb = b;
        case (op)
            3'b000: return p[31:0];
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return sa / sb;
            end
            3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit isSpecial(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        return op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    // Issue one request, hold valid until ready, then drop it; lat counts edges after accept.
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busyCnt);
        @(negedge clk);
        mdu_op = op; rs1 = a; rs2 = b; mdu_valid = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        busyCnt = mdu_busy ? 1 : 0;
        while (!mdu_ready && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (mdu_busy) busyCnt++;
        end
        res = mdu_result;
        @(negedge clk);
        mdu_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mdu_valid = 1'b0; mdu_op = 3'b000; rs1 = '0; rs2 = '0;
        #12;
        checks++;
        if (mdu_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", mdu_ready); end
        checks++;
        if (mdu_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", mdu_busy); end
        checks++;
        if (mdu_result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 0", mdu_result); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mul_latency();
        logic [31:0] res; int lat, busyCnt;
        runOp(3'b000, 32'd7, 32'hFFFFFFFD, res, lat, busyCnt);
        checks++;
        if (res !== 32'hFFFFFFEB) begin errors++; $display("[TB] FAIL mul_result: got %h expected ffffffeb", res); end
        checks++;
        if (lat != NORMAL_LAT) begin errors++; $display("[TB] FAIL mul_latency: got %0d expected %0d", lat, NORMAL_LAT); end
        checks++;
        if (busyCnt != NORMAL_LAT) begin errors++; $display("[TB] FAIL mul_busy_cycles: got %0d expected %0d", busyCnt, NORMAL_LAT); end
    endtask

    task automatic test_directed();
        logic [2:0]  ops [7] = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] as  [7] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] bs  [7] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exs [7] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        logic [31:0] res; int lat, busyCnt;
        for (int i = 0; i < 7; i++) begin
            runOp(ops[i], as[i], bs[i], res, lat, busyCnt);
            checks++;
            if (res !== exs[i]) begin errors++; $display("[TB] FAIL directed_%0d op %b: got %h expected %h", i, ops[i], res, exs[i]); end
            checks++;
            if (lat != NORMAL_LAT) begin errors++; $display("[TB] FAIL directed_lat_%0d: got %0d expected %0d", i, lat, NORMAL_LAT); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [4] = '{3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exs [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
        logic [31:0] res; int lat, busyCnt;
        for (int i = 0; i < 4; i++) begin
            runOp(ops[i], as[i], bs[i], res, lat, busyCnt);
            checks++;
            if (res !== exs[i]) begin errors++; $display("[TB] FAIL special_%0d: got %h expected %h", i, res, exs[i]); end
            checks++;
            if (lat != 0 || busyCnt != 0) begin errors++; $display("[TB] FAIL special_lat_%0d: got lat %0d busy %0d expected ready at accept edge", i, lat, busyCnt); end
        end
    endtask

    task automatic test_handshake();
        logic [31:0] expected;
        int waited;
        expected = refModel(3'b000, 32'h12345, 32'h777);
        @(negedge clk);
        mdu_op = 3'b000; rs1 = 32'h12345; rs2 = 32'h777; mdu_valid = 1'b1;
        repeat (6) @(negedge clk);
        rs1 = 32'hDEADBEEF; mdu_op = 3'b101;
        waited = 0;
        while (!mdu_ready && waited < 100) begin
            @(posedge clk); #1; waited++;
        end
        checks++;
        if (mdu_result !== expected) begin errors++; $display("[TB] FAIL hs_operand_change: got %h expected %h", mdu_result, expected); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (mdu_ready !== 1'b1 || mdu_busy !== 1'b0 || mdu_result !== expected) begin
                errors++;
                $display("[TB] FAIL hs_hold_%0d: got ready %b busy %b result %h expected 1 0 %h", i, mdu_ready, mdu_busy, mdu_result, expected);
            end
        end
        @(negedge clk);
        mdu_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mdu_ready !== 1'b0 || mdu_busy !== 1'b0) begin errors++; $display("[TB] FAIL hs_release: got ready %b busy %b expected 0 0", mdu_ready, mdu_busy); end
    endtask

    task automatic test_valid_drop();
        logic [31:0] a, b, expected;
        int waited;
        a = $urandom; b = $urandom_range(1, 1000);
        expected = refModel(3'b101, a, b);
        @(negedge clk);
        mdu_op = 3'b101; rs1 = a; rs2 = b; mdu_valid = 1'b1;
        repeat (3) @(negedge clk);
        mdu_valid = 1'b0;
        waited = 0;
        while (!mdu_ready && waited < 100) begin
            @(posedge clk); #1; waited++;
        end
        checks++;
        if (mdu_ready !== 1'b1 || mdu_result !== expected) begin errors++; $display("[TB] FAIL drop_result: got ready %b result %h expected 1 %h", mdu_ready, mdu_result, expected); end
        @(posedge clk); #1;
        checks++;
        if (mdu_ready !== 1'b0) begin errors++; $display("[TB] FAIL drop_pulse: got ready %b expected 0", mdu_ready); end
    endtask

    task automatic test_random();
        logic [2:0] op; logic [31:0] a, b, res, expected;
        int lat, busyCnt, expLat;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: begin a = $urandom_range(0, 50); b = $urandom_range(0, 9); end
                3: b = 32'($signed(-$urandom_range(1, 20)));
                default: ;
            endcase
            expected = refModel(op, a, b);
            expLat = isSpecial(op, a, b) ? 0 : NORMAL_LAT;
            runOp(op, a, b, res, lat, busyCnt);
            checks++;
            if (res !== expected || lat != expLat) begin
                errors++;
                $display("[TB] FAIL random_%0d op %b a %h b %h: got %h lat %0d expected %h lat %0d", i, op, a, b, res, lat, expected, expLat);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] res; int lat, busyCnt;
        runOp(3'b000, 32'd3, 32'd5, res, lat, busyCnt);
        checks++;
        if (res !== 32'd15) begin errors++; $display("[TB] FAIL pre_reset_mul: got %h expected f", res); end
        @(negedge clk);
        mdu_op = 3'b100; rs1 = 32'hFFFF0000; rs2 = 32'd3; mdu_valid = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (mdu_ready !== 1'b0 || mdu_busy !== 1'b0 || mdu_result !== 32'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: got ready %b busy %b result %h expected 0 0 0", mdu_ready, mdu_busy, mdu_result);
        end
        mdu_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        runOp(3'b000, 32'd3, 32'd4, res, lat, busyCnt);
        checks++;
        if (res !== 32'd12 || lat != NORMAL_LAT) begin errors++; $display("[TB] FAIL post_reset_mul: got %h lat %0d expected c lat %0d", res, lat, NORMAL_LAT); end
    endtask

    initial begin
        test_reset();
        test_mul_latency();
        test_directed();
        test_special();
        test_handshake();
        test_valid_drop();
        test_random();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
